lockstep_ctrl: RTL and testbench

LOCKSTEP_CTRL -- requirements
Module: lockstep_ctrl

---
 rtl/lockstep_pkg.sv | 32 +++
 rtl/lockstep_cmp.sv | 32 +++
 rtl/lockstep_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_lockstep_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lockstep_pkg.sv
// Shared types for the lockstep controller: FSM states, mask bit indices
// and the per-CPU bus bundle. Optional feature macro: LOCKSTEP_CTRL_CYCQUAL_EN.
package lockstep_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RESET,
    ST_RUN,
    ST_DONE
  } state_e;

  localparam int unsigned M_ADR  = 0;
  localparam int unsigned M_DAT  = 1;
  localparam int unsigned M_SEL  = 2;
  localparam int unsigned M_CYC  = 3;
  localparam int unsigned M_WE   = 4;
  localparam int unsigned M_HALT = 5;
  localparam int unsigned M_INT  = 6;
  localparam int unsigned M_EX   = 7;

  typedef struct packed {
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic [3:0]  ex;
    logic        cyc;
    logic        we;
    logic        halt;
    logic        intr;
  } cpu_bus_t;

endpackage

// File: rtl/lockstep_cmp.sv
// Combinational field comparator between the two CPU bus sets.
// LOCKSTEP_CTRL_CYCQUAL_EN ignores bus fields while both cyc are low.
module lockstep_cmp
  import lockstep_pkg::*;
(
  input  cpu_bus_t   a_i,
  input  cpu_bus_t   b_i,
  output logic [7:0] mask_o
);

  always_comb begin
    mask_o         = '0;
    mask_o[M_ADR]  = a_i.adr  != b_i.adr;
    mask_o[M_DAT]  = a_i.dat  != b_i.dat;
    mask_o[M_SEL]  = a_i.sel  != b_i.sel;
    mask_o[M_CYC]  = a_i.cyc  != b_i.cyc;
    mask_o[M_WE]   = a_i.we   != b_i.we;
    mask_o[M_HALT] = a_i.halt != b_i.halt;
    mask_o[M_INT]  = a_i.intr != b_i.intr;
    mask_o[M_EX]   = a_i.ex   != b_i.ex;
`ifdef LOCKSTEP_CTRL_CYCQUAL_EN
    // idle bus: address/data lanes carry no meaning
    if (!a_i.cyc && !b_i.cyc) begin
      mask_o[M_ADR] = 1'b0;
      mask_o[M_DAT] = 1'b0;
      mask_o[M_SEL] = 1'b0;
      mask_o[M_WE]  = 1'b0;
    end
`endif
  end

endmodule

// File: rtl/lockstep_ctrl.sv
// Lockstep test controller: resets two CPUs, compares them every cycle,
// reports pass/fail/timeout. Optional macro: LOCKSTEP_CTRL_CYCQUAL_EN.
module lockstep_ctrl
  import lockstep_pkg::*;
#(
  parameter int unsigned RESET_CYCLES = 4,
  parameter int unsigned TIMEOUT      = 100000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [31:0] adr1_i,
  input  logic [31:0] adr2_i,
  input  logic [31:0] dat1_i,
  input  logic [31:0] dat2_i,
  input  logic [3:0]  sel1_i,
  input  logic [3:0]  sel2_i,
  input  logic [3:0]  ex1_i,
  input  logic [3:0]  ex2_i,
  input  logic        cyc1_i,
  input  logic        cyc2_i,
  input  logic        we1_i,
  input  logic        we2_i,
  input  logic        halt1_i,
  input  logic        halt2_i,
  input  logic        int1_i,
  input  logic        int2_i,
  output logic        cpu_rst_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        pass_o,
  output logic        fail_o,
  output logic        timeout_o,
  output logic [31:0] cycle_cnt_o,
  output logic [31:0] fail_cycle_o,
  output logic [7:0]  fail_mask_o,
  output logic [31:0] fail_adr1_o,
  output logic [31:0] fail_adr2_o
);

  localparam logic [7:0]  RST_LAST = 8'(RESET_CYCLES - 1);
  localparam logic [31:0] TO_LAST  = 32'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [7:0]  rcnt_q, rcnt_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] fcyc_q, fcyc_d;
  logic [31:0] a1_q, a1_d;
  logic [31:0] a2_q, a2_d;
  logic [7:0]  fmask_q, fmask_d;
  logic        pass_q, pass_d;
  logic        fail_q, fail_d;
  logic        tmo_q, tmo_d;

  cpu_bus_t    c1, c2;
  logic [7:0]  mask;
  logic        mism, both_halt, tmo_hit;

  assign c1.adr  = adr1_i;
  assign c1.dat  = dat1_i;
  assign c1.sel  = sel1_i;
  assign c1.ex   = ex1_i;
  assign c1.cyc  = cyc1_i;
  assign c1.we   = we1_i;
  assign c1.halt = halt1_i;
  assign c1.intr = int1_i;
  assign c2.adr  = adr2_i;
  assign c2.dat  = dat2_i;
  assign c2.sel  = sel2_i;
  assign c2.ex   = ex2_i;
  assign c2.cyc  = cyc2_i;
  assign c2.we   = we2_i;
  assign c2.halt = halt2_i;
  assign c2.intr = int2_i;

  lockstep_cmp u_cmp (
    .a_i    (c1),
    .b_i    (c2),
    .mask_o (mask)
  );

  assign mism      = |mask;
  assign both_halt = halt1_i & halt2_i;
  assign tmo_hit   = cnt_q == TO_LAST;

  always_ff @(posedge clk_i) begin
    if (!rst_i) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE, ST_DONE:
        if (start_i) state_d = ST_RESET;
      ST_RESET:
        if (rcnt_q == RST_LAST) state_d = ST_RUN;
      ST_RUN:
        if (mism || both_halt || tmo_hit)
          state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cpu_rst_o = 1'b1;
    busy_o    = 1'b0;
    unique case (state_q)
      ST_RESET: busy_o = 1'b1;
      ST_RUN: begin
        cpu_rst_o = 1'b0;
        busy_o    = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    rcnt_d  = rcnt_q;
    cnt_d   = cnt_q;
    fcyc_d  = fcyc_q;
    a1_d    = a1_q;
    a2_d    = a2_q;
    fmask_d = fmask_q;
    pass_d  = pass_q;
    fail_d  = fail_q;
    tmo_d   = tmo_q;
    unique case (state_q)
      ST_IDLE, ST_DONE:
        if (start_i) begin
          rcnt_d  = '0;
          cnt_d   = '0;
          fcyc_d  = '0;
          a1_d    = '0;
          a2_d    = '0;
          fmask_d = '0;
          pass_d  = 1'b0;
          fail_d  = 1'b0;
          tmo_d   = 1'b0;
        end
      ST_RESET: rcnt_d = rcnt_q + 8'd1;
      ST_RUN: begin
        // counter freezes on the final RUN cycle
        if (mism) begin
          fail_d  = 1'b1;
          fcyc_d  = cnt_q;
          fmask_d = mask;
          a1_d    = adr1_i;
          a2_d    = adr2_i;
        end else if (both_halt) begin
          pass_d = 1'b1;
        end else if (tmo_hit) begin
          fail_d = 1'b1;
          tmo_d  = 1'b1;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      rcnt_q  <= '0;
      cnt_q   <= '0;
      fcyc_q  <= '0;
      a1_q    <= '0;
      a2_q    <= '0;
      fmask_q <= '0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      rcnt_q  <= rcnt_d;
      cnt_q   <= cnt_d;
      fcyc_q  <= fcyc_d;
      a1_q    <= a1_d;
      a2_q    <= a2_d;
      fmask_q <= fmask_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      tmo_q   <= tmo_d;
    end
  end

  assign done_o       = pass_q | fail_q;
  assign pass_o       = pass_q;
  assign fail_o       = fail_q;
  assign timeout_o    = tmo_q;
  assign cycle_cnt_o  = cnt_q;
  assign fail_cycle_o = fcyc_q;
  assign fail_mask_o  = fmask_q;
  assign fail_adr1_o  = a1_q;
  assign fail_adr2_o  = a2_q;

endmodule

// File: tb/tb_lockstep_ctrl.sv
// Scoreboard bench for lockstep_ctrl: a cycle-list model predicts each
// test outcome; a monitor checks it when done_o rises. Honours LOCKSTEP_CTRL_CYCQUAL_EN.
module tb_lockstep_ctrl;

  localparam int TO   = 60;
  localparam int RSTC = 4;

  typedef struct {
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic [3:0]  ex;
    logic        cyc;
    logic        we;
    logic        halt;
    logic        intr;
  } bus_t;

  typedef struct {
    logic        pass;
    logic        fail;
    logic        tmo;
    logic [31:0] cnt;
    logic [31:0] fcyc;
    logic [7:0]  mask;
    logic [31:0] a1;
    logic [31:0] a2;
  } exp_t;

  logic clk = 0;
  logic rst = 0;
  logic start = 0;
  logic [31:0] adr1, adr2, dat1, dat2;
  logic [3:0]  sel1, sel2, ex1, ex2;
  logic cyc1, cyc2, we1, we2;
  logic halt1, halt2, int1, int2;
  logic cpu_rst_o, busy_o, done_o;
  logic pass_o, fail_o, timeout_o;
  logic [31:0] cycle_cnt_o, fail_cycle_o;
  logic [7:0]  fail_mask_o;
  logic [31:0] fail_adr1_o, fail_adr2_o;

  bus_t s1[TO];
  bus_t s2[TO];
  exp_t q_exp[$];
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  lockstep_ctrl #(
    .RESET_CYCLES (RSTC),
    .TIMEOUT      (TO)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .start_i      (start),
    .adr1_i       (adr1),
    .adr2_i       (adr2),
    .dat1_i       (dat1),
    .dat2_i       (dat2),
    .sel1_i       (sel1),
    .sel2_i       (sel2),
    .ex1_i        (ex1),
    .ex2_i        (ex2),
    .cyc1_i       (cyc1),
    .cyc2_i       (cyc2),
    .we1_i        (we1),
    .we2_i        (we2),
    .halt1_i      (halt1),
    .halt2_i      (halt2),
    .int1_i       (int1),
    .int2_i       (int2),
    .cpu_rst_o    (cpu_rst_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .pass_o       (pass_o),
    .fail_o       (fail_o),
    .timeout_o    (timeout_o),
    .cycle_cnt_o  (cycle_cnt_o),
    .fail_cycle_o (fail_cycle_o),
    .fail_mask_o  (fail_mask_o),
    .fail_adr1_o  (fail_adr1_o),
    .fail_adr2_o  (fail_adr2_o)
  );

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  function automatic bus_t rnd_bus();
    bus_t b;
    b.adr  = $urandom;
    b.dat  = $urandom;
    b.sel  = 4'($urandom);
    b.ex   = 4'($urandom);
    b.cyc  = 1'($urandom);
    b.we   = 1'($urandom);
    b.halt = 1'b0;
    b.intr = 1'($urandom);
    return b;
  endfunction

  task automatic gen_clean();
    for (int n = 0; n < TO; n++) begin
      s1[n] = rnd_bus();
      s2[n] = s1[n];
    end
  endtask

  task automatic perturb(input int n, input logic [7:0] f);
    if (f[0]) s2[n].adr  = s2[n].adr ^ ($urandom | 32'd1);
    if (f[1]) s2[n].dat  = s2[n].dat ^ ($urandom | 32'd1);
    if (f[2]) s2[n].sel  = s2[n].sel ^ 4'($urandom_range(1, 15));
    if (f[3]) s2[n].cyc  = ~s2[n].cyc;
    if (f[4]) s2[n].we   = ~s2[n].we;
    if (f[5]) s2[n].halt = ~s2[n].halt;
    if (f[6]) s2[n].intr = ~s2[n].intr;
    if (f[7]) s2[n].ex   = s2[n].ex ^ 4'($urandom_range(1, 15));
  endtask

  // Outcome of a test: walk the RUN cycles in order and stop at the
  // first cycle that differs, dual-halts or hits the timeout.
  function automatic exp_t model();
    exp_t e;
    logic [7:0] m;
    e = '{default: '0};
    for (int n = 0; n < TO; n++) begin
      m = {s1[n].ex != s2[n].ex,
           s1[n].intr != s2[n].intr,
           s1[n].halt != s2[n].halt,
           s1[n].we != s2[n].we,
           s1[n].cyc != s2[n].cyc,
           s1[n].sel != s2[n].sel,
           s1[n].dat != s2[n].dat,
           s1[n].adr != s2[n].adr};
`ifdef LOCKSTEP_CTRL_CYCQUAL_EN
      if (!s1[n].cyc && !s2[n].cyc) m = m & 8'hE8;
`endif
      e.cnt = 32'(n);
      if (m != 0) begin
        e.fail = 1;
        e.fcyc = 32'(n);
        e.mask = m;
        e.a1   = s1[n].adr;
        e.a2   = s2[n].adr;
        return e;
      end
      if (s1[n].halt && s2[n].halt) begin
        e.pass = 1;
        return e;
      end
    end
    e.fail = 1;
    e.tmo  = 1;
    return e;
  endfunction

  task automatic apply(input int k);
    adr1 = s1[k].adr;  adr2 = s2[k].adr;
    dat1 = s1[k].dat;  dat2 = s2[k].dat;
    sel1 = s1[k].sel;  sel2 = s2[k].sel;
    ex1  = s1[k].ex;   ex2  = s2[k].ex;
    cyc1 = s1[k].cyc;  cyc2 = s2[k].cyc;
    we1  = s1[k].we;   we2  = s2[k].we;
    halt1 = s1[k].halt; halt2 = s2[k].halt;
    int1 = s1[k].intr; int2 = s2[k].intr;
  endtask

  task automatic check_idle(input string t);
    check({t, "_cpurst"}, 32'(cpu_rst_o), 1);
    check({t, "_busy"}, 32'(busy_o), 0);
    check({t, "_done"}, 32'(done_o), 0);
    check({t, "_pf"}, {29'd0, pass_o, fail_o, timeout_o}, 0);
    check({t, "_cnt"}, cycle_cnt_o, 0);
    check({t, "_fcyc"}, fail_cycle_o, 0);
    check({t, "_mask"}, 32'(fail_mask_o), 0);
    check({t, "_adr"}, fail_adr1_o | fail_adr2_o, 0);
  endtask

  // abort_at < 0: run to completion; else pull reset in that RUN cycle
  task automatic run_plan(input int abort_at, input bit noise);
    int w;
    int k;
    bit seen;
    if (abort_at < 0) q_exp.push_back(model());
    @(negedge clk);
    apply(0);
    start = 1;
    @(negedge clk);
    start = 0;
    check("start_clr", {30'd0, done_o, busy_o}, 1);
    w = 0;
    while (cpu_rst_o && w < 20) begin
      w++;
      @(negedge clk);
    end
    check("reset_len", 32'(w), RSTC);
    check("run_entry", {30'd0, cpu_rst_o, busy_o}, 1);
    k = 0;
    seen = 0;
    while (k < TO + 2) begin
      apply(k < TO ? k : TO - 1);
      start = noise ? 1'($urandom) : 1'b0;
      if (k == abort_at) begin
        start = 0;
        rst = 0;
      end
      @(negedge clk);
      if (k == abort_at) break;
      if (done_o) begin
        seen = 1;
        break;
      end
      k++;
    end
    start = 0;
    if (abort_at >= 0) begin
      check_idle("abort");
      rst = 1;
    end else if (!seen) begin
      check("done_seen", 0, 1);
      void'(q_exp.pop_back());
    end
  endtask

  initial begin : monitor
    logic prev;
    exp_t e;
    prev = 0;
    forever begin
      @(negedge clk);
      if (done_o && !prev) begin
        if (q_exp.size() == 0) begin
          check("sb_unexpected", 1, 0);
        end else begin
          e = q_exp.pop_front();
          check("pass", 32'(pass_o), 32'(e.pass));
          check("fail", 32'(fail_o), 32'(e.fail));
          check("timeout", 32'(timeout_o), 32'(e.tmo));
          check("cycle_cnt", cycle_cnt_o, e.cnt);
          check("fail_cycle", fail_cycle_o, e.fcyc);
          check("fail_mask", 32'(fail_mask_o), 32'(e.mask));
          check("fail_adr1", fail_adr1_o, e.a1);
          check("fail_adr2", fail_adr2_o, e.a2);
        end
      end
      prev = done_o;
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got hang expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int h;
    int m;
    gen_clean();
    apply(0);
    repeat (3) @(negedge clk);
    check_idle("reset");
    rst = 1;
    @(negedge clk);
    check_idle("idle");

    gen_clean();
    s1[50].halt = 1;
    s2[50].halt = 1;
    run_plan(-1, 0);

    gen_clean();
    s1[10].adr = 32'h1000;
    s2[10].adr = 32'h1000;
    s1[10].cyc = 1;
    s2[10].cyc = 1;
    s2[10].dat = s1[10].dat ^ 32'd1;
    run_plan(-1, 0);

    gen_clean();
    run_plan(-1, 0);

    gen_clean();
    s1[12].cyc = 1;
    s2[12].cyc = 1;
    s1[12].halt = 1;
    s2[12].adr = s1[12].adr ^ 32'd4;
    run_plan(-1, 0);

    gen_clean();
    s2[TO-1].intr = ~s1[TO-1].intr;
    run_plan(-1, 0);

    gen_clean();
    s1[7].cyc = 0;
    s2[7].cyc = 0;
    s2[7].adr = s1[7].adr ^ 32'd4;
    s1[40].halt = 1;
    s2[40].halt = 1;
    run_plan(-1, 0);

    gen_clean();
    run_plan(5, 0);

    for (int i = 0; i < 24; i++) begin
      gen_clean();
      h = $urandom_range(0, TO + 10);
      m = $urandom_range(0, TO + 10);
      if (h < TO) begin
        s1[h].halt = 1;
        s2[h].halt = 1;
      end
      if (m < TO) perturb(m, 8'($urandom_range(1, 255)));
      run_plan(-1, 1);
    end

    repeat (3) @(negedge clk);
    check("sb_drain", 32'(q_exp.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
